// File: rtl/pipelined_cpa_block_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cpa_block_if
// Purpose  : Operand/result handshake bundle for pipelined_cpa_block.
//            Upstream side offers operand beats (in_valid/in_ready) and the
//            downstream side drains results (out_valid/out_ready).
// Ports    : in_valid, in_ready, a, b, sub, cin   - operand beat
//            out_valid, out_ready, sum, cout, ovf - result beat
// Modports : master - the surrounding logic (drives operands, out_ready)
//            slave  - the adder block itself
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_cpa_block_if #(
  parameter int N = 40
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_cpa_block.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cpa_block
// Purpose  : Pipelined carry-propagate adder/subtractor. Computes
//            a + (b ^ {N{sub}}) + (cin ^ sub), resolving W bits per stage
//            with SEG-bit carry-lookahead segments chained inside a stage.
//            The carry is registered between stages, so no carry path spans
//            stages. L = N/W register stages; L must be at least 2.
// Params   : N   - operand/result width
//            SEG - bits per lookahead segment (W must be a multiple of SEG)
//            W   - bits resolved per stage (N must be a multiple of W)
// Ports    : clk - clock, rising edge
//            rst - asynchronous active-high reset
//            bus - pipelined_cpa_block_if.slave (operand/result handshake)
// Config   : PIPELINED_CPA_SATURATE_EN - when defined, sum saturates toward
//            the sign of a on signed overflow; ovf/cout unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_cpa_block #(
  parameter int N   = 40,
  parameter int SEG = 4,
  parameter int W   = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  pipelined_cpa_block_if.slave    bus
);

  localparam int L    = N / W;
  localparam int NSEG = W / SEG;

  // --------------------------------------------------------------------------
  // One W-bit slice. Inside each segment every carry is a flat
  // generate/propagate lookahead term from the segment carry-in; segments
  // chain through their carry-out. Returns {carry_into_top, cout, sum}.
  // --------------------------------------------------------------------------
  function automatic logic [W+1:0] f_slice_add(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         ci
  );
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         acc;
    logic         term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int s = 0; s < NSEG; s++) begin
      for (int i = 0; i < SEG; i++) begin
        acc = 1'b0;
        for (int j = 0; j <= i; j++) begin
          term = g[s*SEG+j];
          for (int m = j + 1; m <= i; m++) begin
            term = term & p[s*SEG+m];
          end
          acc = acc | term;
        end
        term = c[s*SEG];
        for (int m = 0; m <= i; m++) begin
          term = term & p[s*SEG+m];
        end
        c[s*SEG+i+1] = acc | term;
      end
    end
    return {c[W-1], c[W], p ^ c[W-1:0]};
  endfunction

  // Stage registers. Operand registers exist only for stages that still
  // have a successor; the last stage holds just the resolved result.
  logic [L-1:0]        r_v;
  logic [L-1:0]        r_c;
  logic [L-1:0]        r_cm;
  logic [L-1:0][N-1:0] r_s;
  logic [L-2:0][N-1:0] r_a;
  logic [L-2:0][N-1:0] r_b;

  // Inputs seen by each stage, and what each stage will register.
  logic [L-1:0]        w_src_v;
  logic [L-1:0]        w_src_c;
  logic [L-1:0][N-1:0] w_src_s;
  logic [L-1:0][N-1:0] w_src_a;
  logic [L-1:0][N-1:0] w_src_b;
  logic [L-1:0][N-1:0] w_nx_s;
  logic [L-1:0]        w_nx_c;
  logic [L-1:0]        w_nx_cm;
  logic [W+1:0]        w_slice;
  logic                w_adv;
  logic                w_ovf;

  // Whole pipe moves together; an empty output slot never blocks.
  assign w_adv        = !r_v[L-1] | bus.out_ready;
  assign bus.in_ready = w_adv;

  always_comb begin
    w_src_v    = '0;
    w_src_c    = '0;
    w_src_s    = '0;
    w_src_a    = '0;
    w_src_b    = '0;
    w_src_v[0] = bus.in_valid & w_adv;
    w_src_c[0] = bus.cin ^ bus.sub;
    w_src_a[0] = bus.a;
    w_src_b[0] = bus.b ^ {N{bus.sub}};
    for (int k = 1; k < L; k++) begin
      w_src_v[k] = r_v[k-1];
      w_src_c[k] = r_c[k-1];
      w_src_s[k] = r_s[k-1];
      w_src_a[k] = r_a[k-1];
      w_src_b[k] = r_b[k-1];
    end
  end

  always_comb begin
    w_nx_s  = w_src_s;
    w_nx_c  = '0;
    w_nx_cm = '0;
    w_slice = '0;
    for (int k = 0; k < L; k++) begin
      w_slice = f_slice_add(w_src_a[k][k*W +: W], w_src_b[k][k*W +: W], w_src_c[k]);
      w_nx_s[k][k*W +: W] = w_slice[W-1:0];
      w_nx_c[k]           = w_slice[W];
      w_nx_cm[k]          = w_slice[W+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v  <= '0;
      r_c  <= '0;
      r_cm <= '0;
      r_s  <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < L; k++) begin
        r_v[k]  <= w_src_v[k];
        r_c[k]  <= w_nx_c[k];
        r_cm[k] <= w_nx_cm[k];
        r_s[k]  <= w_nx_s[k];
      end
      for (int k = 0; k < L - 1; k++) begin
        r_a[k] <= w_src_a[k];
        r_b[k] <= w_src_b[k];
      end
    end
  end

  assign w_ovf         = r_cm[L-1] ^ r_c[L-1];
  assign bus.out_valid = r_v[L-1];
  assign bus.cout      = r_c[L-1];
  assign bus.ovf       = w_ovf;

`ifdef PIPELINED_CPA_SATURATE_EN
  // Sign of a rides alongside the last slice so the clamp direction is known.
  logic r_sign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign <= 1'b0;
    end else if (w_adv) begin
      r_sign <= w_src_a[L-1][N-1];
    end
  end

  assign bus.sum = !w_ovf ? r_s[L-1] :
                   (r_sign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}});
`else
  assign bus.sum = r_s[L-1];
`endif

  // Operand bits below a stage's slice are already folded into the sum and
  // the intermediate carry-into-top bits only matter at the last stage.
  logic w_unused;
  assign w_unused = ^{w_src_a, w_src_b, r_cm[L-2:0]};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cpa_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_cpa_block
// Purpose  : Self-checking bench for pipelined_cpa_block (default params).
//            Directed vector table plus streaming/backpressure and
//            mid-flight reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_cpa_block;
  localparam int N   = 40;
  localparam int SEG = 4;
  localparam int W   = 8;
  localparam int L   = N / W;
  localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINN = {1'b1, {(N-1){1'b0}}};
`ifdef PIPELINED_CPA_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipelined_cpa_block_if #(.N(N)) bus ();

  pipelined_cpa_block #(.N(N), .SEG(SEG), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         cin;
    logic [N-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [N+1:0] act, input logic [N+1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference: plain wide add, overflow from operand/result signs.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic sub, input logic cin);
    logic [N:0]   t;
    logic [N-1:0] bx;
    logic [N-1:0] s;
    logic         o;
    bx = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, cin ^ sub};
    o  = (a[N-1] == bx[N-1]) && (t[N-1] != a[N-1]);
    s  = t[N-1:0];
    if (SAT && o) s = a[N-1] ? MINN : MAXP;
    return {o, t[N], s};
  endfunction

  function automatic logic [N-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[N-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat into an empty pipe; count edges from acceptance to result.
  task automatic run_one(input vec_t v, input string nm);
    int edges;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.sub      = v.sub;
    bus.cin      = v.cin;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 20) begin
      tick();
      edges++;
    end
    check({nm, "_latency"}, (N+2)'(edges), (N+2)'(L));
    check({nm, "_sum"}, {2'b00, bus.sum}, {2'b00, v.exp_sum});
    check({nm, "_cout"}, {{(N+1){1'b0}}, bus.cout}, {{(N+1){1'b0}}, v.exp_cout});
    check({nm, "_ovf"}, {{(N+1){1'b0}}, bus.ovf}, {{(N+1){1'b0}}, v.exp_ovf});
    tick();
  endtask

  logic [N+1:0] exp_q[$];
  logic [N-1:0] sa[8];
  logic [N-1:0] sb[8];
  logic         ssub[8];
  logic         scin[8];

  initial begin
    // a, b, sub, cin, sum, cout, ovf
    vecs[0] = '{40'hFF_FFFF_FFFF, 40'h1, 1'b0, 1'b0, 40'h00_0000_0000, 1'b1, 1'b0};
    vecs[1] = '{40'h5, 40'h7, 1'b1, 1'b0, 40'hFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{40'h5, 40'h7, 1'b1, 1'b1, 40'hFF_FFFF_FFFD, 1'b0, 1'b0};
    vecs[3] = '{40'h7F_FFFF_FFFF, 40'h1, 1'b0, 1'b0, SAT ? MAXP : 40'h80_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{40'h12_3456_789A, 40'h01_0101_0101, 1'b0, 1'b1, 40'h13_3557_799C, 1'b0, 1'b0};
    vecs[5] = '{40'h80_0000_0000, 40'h1, 1'b1, 1'b0, SAT ? MINN : 40'h7F_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{40'h0, 40'h0, 1'b1, 1'b0, 40'h00_0000_0000, 1'b1, 1'b0};
    vecs[7] = '{40'h00_0000_00FF, 40'h1, 1'b0, 1'b0, 40'h00_0000_0100, 1'b0, 1'b0};
    vecs[8] = '{40'h80_0000_0000, 40'h80_0000_0000, 1'b0, 1'b0, SAT ? MINN : 40'h0, 1'b1, 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;

    // Reset with random live inputs.
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = rnd();
    bus.b        = rnd();
    bus.sub      = 1'($urandom_range(0, 1));
    bus.cin      = 1'($urandom_range(0, 1));
    repeat (3) tick();
    check("rst_out_valid", (N+2)'(bus.out_valid), '0);
    check("rst_sum", (N+2)'(bus.sum), '0);
    check("rst_cout", (N+2)'(bus.cout), '0);
    check("rst_ovf", (N+2)'(bus.ovf), '0);
    check("rst_in_ready", (N+2)'(bus.in_ready), (N+2)'(1));
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_one(vecs[i], $sformatf("vec%0d", i));
    end

    // Streaming with a 3-cycle downstream stall mid-stream.
    sa[0] = 40'hFF_FFFF_FFFF; sb[0] = 40'h1;  ssub[0] = 1'b0; scin[0] = 1'b0;
    sa[1] = 40'h7F_FFFF_FFFF; sb[1] = 40'h1;  ssub[1] = 1'b0; scin[1] = 1'b0;
    sa[2] = 40'h5;            sb[2] = 40'h7;  ssub[2] = 1'b1; scin[2] = 1'b1;
    for (int i = 3; i < 8; i++) begin
      sa[i]   = rnd();
      sb[i]   = rnd();
      ssub[i] = 1'(i % 2);
      scin[i] = 1'((i / 2) % 2);
    end
    begin
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      bit have_snap = 1'b0;
      logic [N+1:0] snap = '0;
      logic [N+1:0] e;
      while (got < 8 && cyc < 200) begin
        bus.in_valid = (sent < 8);
        if (sent < 8) begin
          bus.a   = sa[sent];
          bus.b   = sb[sent];
          bus.sub = ssub[sent];
          bus.cin = scin[sent];
        end
        bus.out_ready = !(cyc >= 6 && cyc < 9);
        @(negedge clk);
        if (!bus.out_ready && bus.out_valid) begin
          check($sformatf("stall_in_ready_c%0d", cyc), (N+2)'(bus.in_ready), '0);
          if (!have_snap) begin
            snap      = {bus.ovf, bus.cout, bus.sum};
            have_snap = 1'b1;
          end else begin
            check($sformatf("stall_hold_c%0d", cyc), {bus.ovf, bus.cout, bus.sum}, snap);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) e = 'x;
          else e = exp_q.pop_front();
          check($sformatf("stream_beat%0d", got), {bus.ovf, bus.cout, bus.sum}, e);
          got++;
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.a, bus.b, bus.sub, bus.cin));
          sent++;
        end
        tick();
        cyc++;
      end
      check("stream_count", (N+2)'(got), (N+2)'(8));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    exp_q.delete();
    repeat (2) tick();

    // Mid-flight reset: three beats in, first one at the output.
    for (int i = 0; i < 3; i++) begin
      bus.a        = rnd();
      bus.b        = rnd();
      bus.sub      = 1'b0;
      bus.cin      = 1'b0;
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check("pre_rst_out_valid", (N+2)'(bus.out_valid), (N+2)'(1));
    #1 rst = 1'b1;
    #1;
    check("async_rst_out_valid", (N+2)'(bus.out_valid), '0);
    check("async_rst_sum", (N+2)'(bus.sum), '0);
    tick();
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    begin
      int stray = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (bus.out_valid) stray++;
      end
      check("post_rst_stray", (N+2)'(stray), '0);
    end
    run_one(vecs[4], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
